// File: rtl/pixel_merger_pkg.sv
// pixel_merger_pkg: shared types for the pixel merger and its output FIFO
package pixel_merger_pkg;
  localparam int RGB_W = 24;
  typedef logic [RGB_W-1:0] rgb_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  typedef struct packed {
    rgb_t colour;
    logic first;
    logic last_x;
    logic last_y;
  } pm_entry_t;
endpackage

// File: rtl/pm_fifo.sv
// pm_fifo: synchronous FIFO of DEPTH (power of 2) entries of type T with full/empty flags
module pm_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  T     din_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push_i ? wr_q + 1'b1 : wr_q;
      rd_q <= pop_i ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
  assign dout_o = mem_q[rd_q];
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/pixel_merger.sv
// pixel_merger: collects pixels from several engines and emits them in raster order.
// Define PIXEL_MERGER_TIMEOUT_EN to fill pixels no engine supplies within TIMEOUT_CYCLES.
module pixel_merger
  import pixel_merger_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RGB_SIZE = 24,
  parameter int SCREEN_WIDTH = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_ENGINES = 6,
  parameter int OUT_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [RGB_SIZE-1:0] FILL_COLOUR = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [NUM_ENGINES-1:0]                pix_valid_i,
  input  logic [NUM_ENGINES-1:0][RGB_SIZE-1:0]  colour_i,
  input  logic [NUM_ENGINES-1:0][DATA_WIDTH-1:0] xpixel_i,
  input  logic [NUM_ENGINES-1:0][DATA_WIDTH-1:0] ypixel_i,
  output logic [NUM_ENGINES-1:0]                taken,
  input  logic                                  ready,
  output logic                                  valid,
  output logic [RGB_SIZE-1:0]                   colour_o,
  output logic                                  first,
  output logic                                  last_x,
  output logic                                  last_y,
  output logic [15:0]                           skip_count
);
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  state_e state_q;
  logic [XW-1:0] ex_q;
  logic [YW-1:0] ey_q;
  logic [NUM_ENGINES-1:0] match, win;
  logic [RGB_SIZE-1:0] win_colour;
  logic run, full, empty, push, fill, at_last_x, at_last_y;
  pm_entry_t din, head;
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ENGINES; i++)
      match[i] = pix_valid_i[i] && xpixel_i[i] == DATA_WIDTH'(ex_q) && ypixel_i[i] == DATA_WIDTH'(ey_q);
  end
  // isolating the lowest set bit gives the lowest-index winner
  assign win = match & (~match + 1'b1);
  always_comb begin
    win_colour = '0;
    for (int i = 0; i < NUM_ENGINES; i++)
      win_colour = win[i] ? colour_i[i] : win_colour;
  end
  assign run = state_q == RUN;
  assign taken = (run && !full) ? win : '0;
  assign at_last_x = ex_q == XW'(SCREEN_WIDTH - 1);
  assign at_last_y = at_last_x && ey_q == YW'(SCREEN_HEIGHT - 1);
  assign push = |taken || fill;
  assign din = '{colour: rgb_t'(fill ? FILL_COLOUR : win_colour), first: ex_q == '0 && ey_q == '0,
                 last_x: at_last_x, last_y: at_last_y};
`ifdef PIXEL_MERGER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic [15:0] skip_q;
  logic idle;
  assign idle = run && !full && match == '0;
  // the fill is pushed in the idle cycle that brings the count to TIMEOUT_CYCLES
  assign fill = idle && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      skip_q <= '0;
    end else begin
      tmo_q <= push ? '0 : idle ? tmo_q + 1'b1 : tmo_q;
      skip_q <= (fill && skip_q != 16'hFFFF) ? skip_q + 1'b1 : skip_q;
    end
  end
  assign skip_count = skip_q;
`else
  assign fill = 1'b0;
  assign skip_count = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ex_q <= '0;
      ey_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= enable ? RUN : IDLE;
        RUN: state_q <= (push && at_last_y) ? DRAIN : RUN;
        DRAIN: state_q <= !empty ? DRAIN : enable ? RUN : IDLE;
        default: state_q <= IDLE;
      endcase
      if (push) begin
        ex_q <= at_last_x ? '0 : ex_q + 1'b1;
        ey_q <= at_last_y ? '0 : at_last_x ? ey_q + 1'b1 : ey_q;
      end
    end
  end
  pm_fifo #(.T(pm_entry_t), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push_i(push), .pop_i(valid && ready),
    .din_i(din), .dout_o(head), .full_o(full), .empty_o(empty)
  );
  assign valid = !empty;
  assign colour_o = valid ? RGB_SIZE'(head.colour) : '0;
  assign first = valid && head.first;
  assign last_x = valid && head.last_x;
  assign last_y = valid && head.last_y;
endmodule

// File: tb/tb_pixel_merger.sv
// tb_pixel_merger: randomized engines feeding pixel_merger, checked against a raster-order scoreboard
module tb_pixel_merger;
  localparam int W = 4, H = 2, N = W * H, NE = 6, DEPTH = 4, TMO = 8;
  localparam logic [23:0] FILL = 24'hA5A5A5;
  typedef struct {int p; logic [23:0] col;} ent_t;
  logic clk = 0, reset = 1, enable = 0, ready = 0;
  logic [NE-1:0] pix_valid_i = '0;
  logic [NE-1:0][23:0] colour_i = '0;
  logic [NE-1:0][31:0] xpixel_i = '0, ypixel_i = '0;
  logic [NE-1:0] taken, tk_now;
  logic valid, first, last_x, last_y;
  logic [23:0] colour_o;
  logic [15:0] skip_count;
  ent_t eng_q[NE][$];
  logic [23:0] col_tab[256];
  bit skip[256];
  int pop_cyc[256];
  int nk = 0, m = 0, cyc = 0, n_taken = 0, n_tests = 0, n_fail = 0, base = 0, b, n0;
  bit rnd_ready = 0, have;
  logic [26:0] snap;

  pixel_merger #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_ENGINES(NE), .OUT_DEPTH(DEPTH),
                 .TIMEOUT_CYCLES(TMO), .FILL_COLOUR(FILL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pix_valid_i(pix_valid_i), .colour_i(colour_i),
    .xpixel_i(xpixel_i), .ypixel_i(ypixel_i), .taken(taken), .ready(ready), .valid(valid),
    .colour_o(colour_o), .first(first), .last_x(last_x), .last_y(last_y), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int e = 0; e < NE; e++) begin
      if (eng_q[e].size() > 0) begin
        pix_valid_i[e] = 1'b1;
        xpixel_i[e] = 32'(eng_q[e][0].p % W);
        ypixel_i[e] = 32'((eng_q[e][0].p / W) % H);
        colour_i[e] = eng_q[e][0].col;
      end else begin
        pix_valid_i[e] = 1'b0;
        xpixel_i[e] = 32'($urandom_range(0, W - 1));
        ypixel_i[e] = 32'($urandom_range(0, H - 1));
        colour_i[e] = 24'($urandom);
      end
    end
    if (rnd_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic monitor();
    int w;
    tk_now = taken;
    if (valid && ready) begin
      check("out_pixel", 32'({colour_o, first, last_x, last_y}),
            32'({col_tab[m], m % N == 0, m % W == W - 1, m % N == N - 1}));
      pop_cyc[m] = cyc;
      m++;
    end
    if (taken != '0) begin
      n_taken++;
      while (skip[nk]) nk++;
      w = -1;
      for (int e = NE - 1; e >= 0; e--)
        if (pix_valid_i[e] && xpixel_i[e] == 32'(nk % W) && ypixel_i[e] == 32'((nk / W) % H)) w = e;
      check("winner", 32'(taken), w < 0 ? 32'd0 : 32'd1 << w);
      for (int e = 0; e < NE; e++)
        if (taken[e] && eng_q[e].size() > 0) void'(eng_q[e].pop_front());
      nk++;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  // pixels bb..bb+n-1 in raster order; gap is left to the timeout fill
  task automatic load(int bb, int n, bit rnd, int gap, int e0);
    for (int k = 0; k < n; k++) begin
      int p = bb + k;
      col_tab[p] = 24'($urandom);
      skip[p] = 0;
      if (k == gap) begin
`ifdef PIXEL_MERGER_TIMEOUT_EN
        skip[p] = 1;
        col_tab[p] = FILL;
`endif
      end else
        eng_q[k == 0 ? e0 : rnd ? $urandom_range(0, NE - 1) : k % NE].push_back('{p, col_tab[p]});
    end
  endtask

  task automatic wait_out(int n, string tag);
    for (int i = 0; i < 400 && m < n; i++) step();
    check(tag, 32'(m), 32'(n));
  endtask

  initial begin
    pix_valid_i = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid), 0);
    check("rst_taken", 32'(taken), 0);
    check("rst_colour", 32'(colour_o), 0);
    check("rst_flags", 32'({first, last_x, last_y}), 0);
    check("rst_skip", 32'(skip_count), 0);
    @(posedge clk);
    #1;
    reset = 0;
    pix_valid_i = '0;
    // raster frame with engine k mod 6 holding pixel k
    enable = 1;
    ready = 1;
    b = base; base += N;
    load(b, N, 0, -1, 0);
    drive();
    wait_out(b + N, "frame_count");
    check("one_per_cycle", 32'(pop_cyc[b + N - 1] - pop_cyc[b]), 32'(N - 1));
    // engines 1 and 4 both hold (0,0)
    b = base; base += N;
    eng_q[4].push_back('{b, 24'($urandom)});
    load(b, N, 0, -1, 1);
    drive();
    tk_now = '0;
    for (int i = 0; i < 20 && tk_now == '0; i++) step();
    check("dup_taken", 32'(tk_now), 32'h02);
    repeat (4) begin
      step();
      check("dup_eng4_held", 32'(tk_now[4]), 0);
    end
    void'(eng_q[4].pop_front());
    drive();
    wait_out(b + N, "dup_frame");
    // downstream stalled for 10 cycles
    b = base; base += N;
    ready = 0;
    n0 = n_taken;
    have = 0;
    load(b, N, 0, -1, 0);
    drive();
    repeat (10) begin
      step();
      if (valid) begin
        if (!have) begin
          snap = {colour_o, first, last_x, last_y};
          have = 1;
        end else check("stall_payload", 32'({colour_o, first, last_x, last_y}), 32'(snap));
      end
    end
    check("full_taken_pulses", 32'(n_taken - n0), DEPTH);
    check("full_no_taken", 32'(tk_now), 0);
    check("full_valid", 32'(valid), 1);
    ready = 1;
    wait_out(b + N, "full_drain");
    // enable dropped mid-frame
    b = base; base += N;
    rnd_ready = 1;
    load(b, N, 1, -1, 0);
    drive();
    for (int i = 0; i < 200 && m < b + 3; i++) step();
    enable = 0;
    wait_out(b + N, "noen_frame");
    b = base; base += N;
    load(b, N, 1, -1, 0);
    drive();
    n0 = n_taken;
    repeat (8) step();
    check("idle_taken", 32'(n_taken - n0), 0);
    check("idle_valid", 32'(valid), 0);
    enable = 1;
    wait_out(b + N, "reen_frame");
    rnd_ready = 0;
    // reset with three pixels buffered
    b = base; base += N;
    ready = 0;
    load(b, N, 0, -1, 0);
    drive();
    n0 = n_taken;
    for (int i = 0; i < 20 && n_taken - n0 < 3; i++) step();
    check("pre_reset_taken", 32'(n_taken - n0), 3);
    reset = 1;
    for (int e = 0; e < NE; e++) eng_q[e].delete();
    drive();
    step();
    check("reset_mid_valid", 32'(valid), 0);
    reset = 0;
    b = base; base += N;
    nk = b;
    m = b;
    ready = 1;
    load(b, N, 0, -1, 0);
    drive();
    wait_out(b + N, "post_reset_frame");
    // randomized engines and backpressure
    rnd_ready = 1;
    repeat (3) begin
      b = base; base += N;
      load(b, N, 1, -1, 0);
      drive();
      wait_out(b + N, "rand_frame");
    end
    rnd_ready = 0;
    ready = 1;
    // nobody holds (2,0)
    b = base; base += N;
    load(b, N, 0, 2, 0);
    drive();
`ifdef PIXEL_MERGER_TIMEOUT_EN
    wait_out(b + N, "tmo_frame");
    check("tmo_skip", 32'(skip_count), 1);
    check("tmo_gap_lo", 32'(pop_cyc[b + 2] - pop_cyc[b + 1] >= TMO), 1);
    check("tmo_gap_hi", 32'(pop_cyc[b + 2] - pop_cyc[b + 1] <= TMO + 1), 1);
`else
    repeat (40) step();
    check("stall_outputs", 32'(m), 32'(b + 2));
    check("stall_valid", 32'(valid), 0);
    check("stall_skip", 32'(skip_count), 0);
    eng_q[3].push_front('{b + 2, col_tab[b + 2]});
    drive();
    wait_out(b + N, "stall_resume");
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
